// File: rtl/mem_controller.sv
//------------------------------------------------------------------------------
// mem_controller : sequences single-word reads/writes through a MAR/MDR pair
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_controller (
    input  logic        clock,
    input  logic        nReset,
    input  logic        req,
    input  logic        rw,
    input  logic [10:0] reqAddr,
    input  logic [15:0] wrData,
    output logic        ready,
    output logic        done,
    output logic [15:0] rdData,
    output logic [10:0] addr,
    inout  wire  [15:0] data,
    output logic        nOutput,
    output logic        nWrite
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_FETCH  = 3'd2,
        S_DRIVE  = 3'd3,
        S_LOAD   = 3'd4,
        S_COMMIT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_rw;
    logic [10:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdData;
    logic        w_drive;

    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_state  <= S_IDLE;
            r_rw     <= 1'b0;
            r_addr   <= 11'd0;
            r_wdata  <= 16'd0;
            r_rdData <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req) begin
                r_rw    <= rw;
                r_addr  <= reqAddr;
                r_wdata <= wrData;
            end
            if (r_state == S_DRIVE)
                r_rdData <= data;
        end
    end

    // Write path strobes twice: LOAD leaves a stale word in SRAM, COMMIT fixes it.
    always_comb begin
        w_next  = r_state;
        ready   = 1'b0;
        done    = 1'b0;
        nOutput = 1'b1;
        nWrite  = 1'b1;
        w_drive = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (req)
                    w_next = S_ADDR;
            end
            S_ADDR:   w_next = r_rw ? S_FETCH : S_LOAD;
            S_FETCH:  w_next = S_DRIVE;
            S_DRIVE: begin
                nOutput = 1'b0;
                w_next  = S_DONE;
            end
            S_LOAD: begin
                nWrite  = 1'b0;
                w_drive = 1'b1;
                w_next  = S_COMMIT;
            end
            S_COMMIT: begin
                nWrite  = 1'b0;
                w_drive = 1'b1;
                w_next  = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    assign addr   = r_addr;
    assign rdData = r_rdData;
    assign data   = w_drive ? r_wdata : 16'bz;

endmodule

`default_nettype wire

// File: tb/tb_mem_controller.sv
//------------------------------------------------------------------------------
// tb_mem_controller : MAR/MDR/SRAM environment plus transaction-level reference
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_controller;

    logic        clock = 1'b0;
    logic        nReset;
    logic        req;
    logic        rw;
    logic [10:0] reqAddr;
    logic [15:0] wrData;
    logic        ready;
    logic        done;
    logic [15:0] rdData;
    logic [10:0] addr;
    wire  [15:0] data;
    logic        nOutput;
    logic        nWrite;

    always #5 clock = ~clock;

    mem_controller dut (
        .clock   (clock),
        .nReset  (nReset),
        .req     (req),
        .rw      (rw),
        .reqAddr (reqAddr),
        .wrData  (wrData),
        .ready   (ready),
        .done    (done),
        .rdData  (rdData),
        .addr    (addr),
        .data    (data),
        .nOutput (nOutput),
        .nWrite  (nWrite)
    );

    // Memory side: MAR register, MDR register, SRAM array; idle bus floats high.
    logic [10:0] r_mar = 11'd0;
    logic [15:0] r_mdr = 16'd0;
    logic [15:0] sram [0:2047];

    pullup (data);
    assign data = nOutput ? 16'bz : r_mdr;

    always @(posedge clock) begin
        r_mar <= addr;
        if (!nWrite) begin
            sram[r_mar] <= r_mdr;
            r_mdr       <= data;
        end else if (nOutput) begin
            r_mdr <= sram[r_mar];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: one transaction in flight, phase = cycles since acceptance.
    logic [15:0] ref_mem [0:2047];
    bit          known   [0:2047];
    bit          mv = 0;
    bit          busy = 0;
    int          phase = 0;
    bit          lrw;
    logic [10:0] la;
    logic [15:0] ld;
    logic [10:0] ea = 11'd0;
    logic [15:0] erd = 16'd0;
    bit          erd_known = 1;
    int          cyc = 0;
    int          acc_cyc = 0;

    always @(posedge clock) begin
        if (!nReset) begin
            if (busy && !lrw && phase >= 2) known[la] = 0;
            busy = 0; ea = 11'd0; erd = 16'd0; erd_known = 1; mv = 1;
        end else if (!busy) begin
            if (req) begin
                busy = 1; phase = 1; lrw = rw; la = reqAddr; ld = wrData;
                ea = reqAddr; acc_cyc = cyc;
            end
        end else begin
            if (phase == 3 && lrw) begin
                erd = ref_mem[la]; erd_known = known[la];
            end
            if (phase == 4) begin
                busy = 0;
                if (!lrw) begin ref_mem[la] = ld; known[la] = 1; end
            end else begin
                phase++;
            end
        end
        cyc++;
    end

    int          nw_cnt = 0;
    int          no_cnt = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    logic [15:0] last_done_rd;
    logic [10:0] done_addrs [$];

    always @(negedge clock) begin
        if (mv) begin
            bit e_rd, e_wr;
            e_rd = busy && lrw && phase == 3;
            e_wr = busy && !lrw && (phase == 2 || phase == 3);
            check("ready",   {15'd0, ready},   {15'd0, !busy});
            check("done",    {15'd0, done},    {15'd0, busy && phase == 4});
            check("nOutput", {15'd0, nOutput}, {15'd0, !e_rd});
            check("nWrite",  {15'd0, nWrite},  {15'd0, !e_wr});
            check("addr",    {5'd0, addr},     {5'd0, ea});
            check("data",    data, e_rd ? r_mdr : (e_wr ? ld : 16'hFFFF));
            if (erd_known) check("rdData", rdData, erd);
        end
        if (!nWrite)  nw_cnt++;
        if (!nOutput) no_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_done_rd  = rdData;
            done_addrs.push_back(addr);
        end
    end

    task automatic xact(input logic r, input logic [10:0] a, input logic [15:0] d);
        int n = 0;
        int dc0;
        while (ready !== 1'b1 && n < 20) begin @(negedge clock); #1; n++; end
        if (n >= 20) begin total++; bad++; $display("FAIL ready_timeout actual=busy required=ready"); end
        nw_cnt = 0; no_cnt = 0; dc0 = done_cnt;
        req = 1'b1; rw = r; reqAddr = a; wrData = d;
        @(negedge clock); #1;
        req = 1'b0; rw = 1'($urandom); reqAddr = 11'($urandom); wrData = 16'($urandom);
        n = 0;
        while (done_cnt == dc0 && n < 10) begin @(negedge clock); #1; n++; end
        if (n >= 10) begin total++; bad++; $display("FAIL done_timeout actual=none required=pulse"); end
        @(negedge clock); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        logic [10:0] exp_addrs [$];
        for (int i = 0; i < 2048; i++) begin
            sram[i] = 16'd0; ref_mem[i] = 16'd0; known[i] = 1;
        end
        nReset = 1'b0; req = 1'b1; rw = 1'b0; reqAddr = 11'h005; wrData = 16'h1234;
        repeat (3) @(negedge clock);
        #1;
        check("rst_ready",   {15'd0, ready},   16'd1);
        check("rst_done",    {15'd0, done},    16'd0);
        check("rst_rdData",  rdData,           16'd0);
        check("rst_addr",    {5'd0, addr},     16'd0);
        check("rst_nWrite",  {15'd0, nWrite},  16'd1);
        check("rst_nOutput", {15'd0, nOutput}, 16'd1);
        check("rst_data",    data,             16'hFFFF);
        nReset = 1'b1; req = 1'b0;

        xact(1'b0, 11'h005, 16'hA5C3);
        check("wr_latency", 16'(last_done_cyc - acc_cyc), 16'd4);
        check("wr_nWrite_cycles", 16'(nw_cnt), 16'd2);
        check("wr_nOutput_cycles", 16'(no_cnt), 16'd0);
        check("wr_sram5", sram[11'h005], 16'hA5C3);

        xact(1'b1, 11'h005, 16'h0000);
        check("rd_latency", 16'(last_done_cyc - acc_cyc), 16'd4);
        check("rd_nOutput_cycles", 16'(no_cnt), 16'd1);
        check("rd_nWrite_cycles", 16'(nw_cnt), 16'd0);
        check("rd_value5", last_done_rd, 16'hA5C3);

        xact(1'b0, 11'h7FF, 16'h1234);
        xact(1'b0, 11'h000, 16'hFFFF);
        check("wr_sram7ff", sram[11'h7FF], 16'h1234);
        xact(1'b1, 11'h7FF, 16'h0000);
        check("rd_value7ff", last_done_rd, 16'h1234);
        xact(1'b1, 11'h000, 16'h0000);
        check("rd_value000", last_done_rd, 16'hFFFF);

        // req held high with a moving address
        dc0 = done_cnt;
        done_addrs.delete();
        for (int i = 0; i < 10; i++) begin
            req = 1'b1; rw = 1'b1; reqAddr = 11'(i * 37 + 3);
            if (ready === 1'b1) exp_addrs.push_back(reqAddr);
            @(negedge clock); #1;
        end
        req = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        check("hold_accepts", 16'(done_cnt - dc0), 16'd2);
        check("hold_ready_seen", 16'(exp_addrs.size()), 16'd2);
        if (exp_addrs.size() == 2 && done_addrs.size() == 2) begin
            check("hold_addr0", {5'd0, done_addrs[0]}, {5'd0, exp_addrs[0]});
            check("hold_addr1", {5'd0, done_addrs[1]}, {5'd0, exp_addrs[1]});
        end

        // reset during COMMIT aborts the write
        dc0 = done_cnt;
        req = 1'b1; rw = 1'b0; reqAddr = 11'h010; wrData = 16'hBEEF;
        @(negedge clock); #1; req = 1'b0;
        @(negedge clock); #1;
        @(negedge clock); #1;
        check("commit_nWrite", {15'd0, nWrite}, 16'd0);
        nReset = 1'b0;
        @(negedge clock); #1;
        nReset = 1'b1;
        check("abort_ready",  {15'd0, ready},  16'd1);
        check("abort_nWrite", {15'd0, nWrite}, 16'd1);
        check("abort_done",   {15'd0, done},   16'd0);
        repeat (5) @(negedge clock);
        #1;
        check("abort_no_done", 16'(done_cnt - dc0), 16'd0);
        xact(1'b1, 11'h005, 16'h0000);
        check("post_abort_latency", 16'(last_done_cyc - acc_cyc), 16'd4);
        check("post_abort_rd", last_done_rd, 16'hA5C3);

        // randomized traffic on a small address set to get read-after-write hits
        for (int i = 0; i < 600; i++) begin
            nReset  = ($urandom % 150) != 0;
            req     = ($urandom % 3) != 0;
            rw      = 1'($urandom);
            reqAddr = ($urandom % 8 == 0) ? 11'h7FF : 11'($urandom_range(0, 7));
            wrData  = 16'($urandom);
            @(negedge clock); #1;
        end
        nReset = 1'b1; req = 1'b0;
        repeat (8) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
